// File: rtl/skin_bbox_detect_if.sv
// Pixel-stream input and bounding-box result bundle for skin_bbox_detect.
// The master drives the binarized pixel stream and receives the box. The
// slave is the detector.
interface skin_bbox_detect_if;
   logic        post_vsync;
   logic        post_de;
   logic        monoc;
   logic [11:0] box_x_min;
   logic [11:0] box_x_max;
   logic [11:0] box_y_min;
   logic [11:0] box_y_max;
   logic        box_found;
   logic        box_valid;

   modport master (
      output post_vsync, post_de, monoc,
      input  box_x_min, box_x_max, box_y_min, box_y_max, box_found, box_valid
   );

   modport slave (
      input  post_vsync, post_de, monoc,
      output box_x_min, box_x_max, box_y_min, box_y_max, box_found, box_valid
   );
endinterface

// File: rtl/skin_bbox_detect.sv
// Skin bounding-box detector.
// Tracks pixel column and row in a binarized skin mask stream. A skin pixel
// only counts once it is the MIN_RUN-th consecutive skin pixel on its line,
// which suppresses speckle. At each frame boundary the box that was
// accumulated over the finished frame is published with a one-cycle
// box_valid pulse. If fewer than MIN_PIX pixels qualified, an empty box is
// published instead.
module skin_bbox_detect #(
   parameter int MIN_RUN = 4,
   parameter int MIN_PIX = 64
) (
   input logic              clk,
   input logic              rst,
   skin_bbox_detect_if.slave bus
);

   localparam int              RUN_W   = $clog2(MIN_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_RUN);
   localparam logic [11:0]     X_OFS   = 12'(MIN_RUN - 1);
   localparam logic [11:0]     CRD_MAX = 12'hFFF;
   localparam logic [21:0]     CNT_MAX = 22'h3FFFFF;

   typedef enum logic {IDLE, ACC} state_t;

   state_t            state_q, state_d;
   logic              vs_q, vs_d;      // previous-cycle post_vsync
   logic              de_q, de_d;      // previous-cycle post_de
   logic [11:0]       x_q, x_d;
   logic [11:0]       y_q, y_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [11:0]       acc_x_min_q, acc_x_min_d;
   logic [11:0]       acc_x_max_q, acc_x_max_d;
   logic [11:0]       acc_y_min_q, acc_y_min_d;
   logic [11:0]       acc_y_max_q, acc_y_max_d;
   logic [21:0]       acc_cnt_q, acc_cnt_d;
   logic [11:0]       box_x_min_q, box_x_min_d;
   logic [11:0]       box_x_max_q, box_x_max_d;
   logic [11:0]       box_y_min_q, box_y_min_d;
   logic [11:0]       box_y_max_q, box_y_max_d;
   logic              box_found_q, box_found_d;
   logic              box_valid_q, box_valid_d;

   logic              fb;
   logic              le;
   logic              pix;
   logic              qual;
   logic [11:0]       x_lo;

   // Next-state logic for counters, accumulators, FSM and box outputs
   always_comb begin
      fb   = bus.post_vsync & ~vs_q;
      le   = ~bus.post_de & de_q;
      // A frame boundary swallows a pixel that arrives in the same cycle.
      pix  = bus.post_de & bus.monoc & ~fb;
      qual = pix & (int'(run_q) >= MIN_RUN - 1);
      // Left edge of a qualified run: the pixel that started it.
      x_lo = x_q - X_OFS;

      state_d     = state_q;
      vs_d        = bus.post_vsync;
      de_d        = bus.post_de;
      x_d         = x_q;
      y_d         = y_q;
      run_d       = '0;
      acc_x_min_d = acc_x_min_q;
      acc_x_max_d = acc_x_max_q;
      acc_y_min_d = acc_y_min_q;
      acc_y_max_d = acc_y_max_q;
      acc_cnt_d   = acc_cnt_q;
      box_x_min_d = box_x_min_q;
      box_x_max_d = box_x_max_q;
      box_y_min_d = box_y_min_q;
      box_y_max_d = box_y_max_q;
      box_found_d = box_found_q;
      box_valid_d = 1'b0;

      if (fb || le)
         x_d = '0;
      else if (bus.post_de && x_q != CRD_MAX)
         x_d = x_q + 12'd1;

      if (fb)
         y_d = '0;
      else if (le && y_q != CRD_MAX)
         y_d = y_q + 12'd1;

      if (pix)
         run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;

      if (fb) begin
         acc_x_min_d = CRD_MAX;
         acc_x_max_d = '0;
         acc_y_min_d = CRD_MAX;
         acc_y_max_d = '0;
         acc_cnt_d   = '0;
      end else if (qual) begin
         if (x_lo < acc_x_min_q) acc_x_min_d = x_lo;
         if (x_q  > acc_x_max_q) acc_x_max_d = x_q;
         if (y_q  < acc_y_min_q) acc_y_min_d = y_q;
         if (y_q  > acc_y_max_q) acc_y_max_d = y_q;
         if (acc_cnt_q != CNT_MAX) acc_cnt_d = acc_cnt_q + 22'd1;
      end

      // The first boundary after reset only opens a frame. Later boundaries
      // publish the frame that just closed.
      if (fb) begin
         state_d = ACC;
         if (state_q == ACC) begin
            box_valid_d = 1'b1;
            if (acc_cnt_q >= 22'(MIN_PIX)) begin
               box_x_min_d = acc_x_min_q;
               box_x_max_d = acc_x_max_q;
               box_y_min_d = acc_y_min_q;
               box_y_max_d = acc_y_max_q;
               box_found_d = 1'b1;
            end else begin
               box_x_min_d = '0;
               box_x_max_d = '0;
               box_y_min_d = '0;
               box_y_max_d = '0;
               box_found_d = 1'b0;
            end
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         vs_q        <= 1'b0;
         de_q        <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         run_q       <= '0;
         acc_x_min_q <= CRD_MAX;
         acc_x_max_q <= '0;
         acc_y_min_q <= CRD_MAX;
         acc_y_max_q <= '0;
         acc_cnt_q   <= '0;
         box_x_min_q <= '0;
         box_x_max_q <= '0;
         box_y_min_q <= '0;
         box_y_max_q <= '0;
         box_found_q <= 1'b0;
         box_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         vs_q        <= vs_d;
         de_q        <= de_d;
         x_q         <= x_d;
         y_q         <= y_d;
         run_q       <= run_d;
         acc_x_min_q <= acc_x_min_d;
         acc_x_max_q <= acc_x_max_d;
         acc_y_min_q <= acc_y_min_d;
         acc_y_max_q <= acc_y_max_d;
         acc_cnt_q   <= acc_cnt_d;
         box_x_min_q <= box_x_min_d;
         box_x_max_q <= box_x_max_d;
         box_y_min_q <= box_y_min_d;
         box_y_max_q <= box_y_max_d;
         box_found_q <= box_found_d;
         box_valid_q <= box_valid_d;
      end
   end

   assign bus.box_x_min = box_x_min_q;
   assign bus.box_x_max = box_x_max_q;
   assign bus.box_y_min = box_y_min_q;
   assign bus.box_y_max = box_y_max_q;
   assign bus.box_found = box_found_q;
   assign bus.box_valid = box_valid_q;

endmodule

// File: tb/tb_skin_bbox_detect.sv
// Testbench for skin_bbox_detect.
// Two detectors share one pixel stream: one uses MIN_PIX=64 and the other
// uses MIN_PIX=1. A line-level reference model decides which pixels qualify
// from the skin mask of each line. A pixel qualifies when it and the
// MIN_RUN-1 pixels before it are all skin.
module tb_skin_bbox_detect;
   localparam int MIN_RUN = 4;
   localparam int PIX0    = 64;
   localparam int PIX1    = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic vs  = 1'b0;
   logic de  = 1'b0;
   logic mo  = 1'b0;

   always #5 clk = ~clk;

   skin_bbox_detect_if bus0();
   skin_bbox_detect_if bus1();
   assign bus0.post_vsync = vs;
   assign bus0.post_de    = de;
   assign bus0.monoc      = mo;
   assign bus1.post_vsync = vs;
   assign bus1.post_de    = de;
   assign bus1.monoc      = mo;

   skin_bbox_detect #(.MIN_RUN(MIN_RUN), .MIN_PIX(PIX0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   skin_bbox_detect #(.MIN_RUN(MIN_RUN), .MIN_PIX(PIX1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int          m_xmin, m_xmax, m_ymin, m_ymax, m_cnt, m_y;
   bit          m_armed;
   logic [49:0] held0, held1;

   // Observed outputs packed as {valid, found, x_min, x_max, y_min, y_max}
   function automatic logic [49:0] obs0();
      return {bus0.box_valid, bus0.box_found, bus0.box_x_min, bus0.box_x_max,
              bus0.box_y_min, bus0.box_y_max};
   endfunction

   function automatic logic [49:0] obs1();
      return {bus1.box_valid, bus1.box_found, bus1.box_x_min, bus1.box_x_max,
              bus1.box_y_min, bus1.box_y_max};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_xmin = 4095; m_xmax = 0; m_ymin = 4095; m_ymax = 0; m_cnt = 0; m_y = 0;
   endtask

   task automatic model_reset();
      model_clear();
      m_armed = 1'b0;
      held0 = '0;
      held1 = '0;
   endtask

   function automatic logic [49:0] box_for(int min_pix);
      if (m_cnt >= min_pix)
         return {2'b11, 12'(m_xmin), 12'(m_xmax), 12'(m_ymin), 12'(m_ymax)};
      return {2'b10, 48'd0};
   endfunction

   // Expected outputs right after a frame boundary. Afterwards the model
   // starts a fresh frame.
   task automatic model_fb(output logic [49:0] e0, output logic [49:0] e1);
      if (m_armed) begin
         e0 = box_for(PIX0);
         e1 = box_for(PIX1);
         held0 = {1'b0, e0[48:0]};
         held1 = {1'b0, e1[48:0]};
      end else begin
         e0 = held0;
         e1 = held1;
      end
      m_armed = 1'b1;
      model_clear();
   endtask

   task automatic model_line(input bit mask[]);
      for (int c = 0; c < mask.size(); c++) begin
         bit q;
         int x;
         int y;
         q = (c >= MIN_RUN - 1);
         for (int k = 0; k < MIN_RUN && q; k++)
            if (!mask[c - k]) q = 1'b0;
         if (q) begin
            x = (c > 4095) ? 4095 : c;
            y = (m_y > 4095) ? 4095 : m_y;
            if (x - (MIN_RUN - 1) < m_xmin) m_xmin = x - (MIN_RUN - 1);
            if (x > m_xmax) m_xmax = x;
            if (y < m_ymin) m_ymin = y;
            if (y > m_ymax) m_ymax = y;
            m_cnt++;
         end
      end
      m_y++;
   endtask

   // One active line followed by two blanking cycles
   task automatic drive_line(input bit mask[]);
      for (int c = 0; c < mask.size(); c++) begin
         de = 1'b1;
         mo = mask[c];
         tick();
      end
      de = 1'b0;
      mo = 1'b0;
      tick();
      tick();
      model_line(mask);
   endtask

   // Frame boundary: a is sampled in the cycle after vsync rises, and b one cycle later
   task automatic do_fb(output logic [49:0] a0, output logic [49:0] a1,
                        output logic [49:0] b0, output logic [49:0] b1);
      vs = 1'b1; de = 1'b0; mo = 1'b0;
      tick();
      a0 = obs0(); a1 = obs1();
      tick();
      b0 = obs0(); b1 = obs1();
      vs = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [49:0] o0, o1;
      #2 rst = 1'b1;
      repeat (3) tick();
      o0 = obs0(); o1 = obs1();
      n_vec++; if (o0 !== 50'd0) begin n_err++; $display("FAIL reset_dut0: got %h want %h", o0, 50'd0); end
      n_vec++; if (o1 !== 50'd0) begin n_err++; $display("FAIL reset_dut1: got %h want %h", o1, 50'd0); end
      rst = 1'b0;
      model_reset();
      tick();
   endtask

   task automatic test_square();
      logic [49:0] a0, a1, b0, b1, e0, e1;
      bit mask[];
      model_fb(e0, e1);
      do_fb(a0, a1, b0, b1);
      n_vec++; if (a0 !== e0) begin n_err++; $display("FAIL square_arm: got %h want %h", a0, e0); end
      for (int r = 0; r < 64; r++) begin
         mask = new[64];
         for (int c = 0; c < 64; c++) mask[c] = (r >= 5 && r <= 24 && c >= 10 && c <= 29);
         drive_line(mask);
      end
      model_fb(e0, e1);
      do_fb(a0, a1, b0, b1);
      n_vec++; if (a0 !== e0) begin n_err++; $display("FAIL square_dut0: got %h want %h", a0, e0); end
      n_vec++; if (a1 !== e1) begin n_err++; $display("FAIL square_dut1: got %h want %h", a1, e1); end
      n_vec++; if (a0 !== {2'b11, 12'd10, 12'd29, 12'd5, 12'd24}) begin
         n_err++; $display("FAIL square_const: got %h want box 10..29 x 5..24", a0); end
      n_vec++; if (b0 !== held0) begin n_err++; $display("FAIL square_pulse_end: got %h want %h", b0, held0); end
   endtask

   task automatic test_short_runs();
      logic [49:0] a0, a1, b0, b1, e0, e1;
      bit mask[];
      for (int r = 0; r < 6; r++) begin
         mask = new[40];
         for (int c = 0; c < 40; c++) mask[c] = ((c % 5) < 3);
         drive_line(mask);
      end
      model_fb(e0, e1);
      do_fb(a0, a1, b0, b1);
      n_vec++; if (a0 !== e0) begin n_err++; $display("FAIL short_dut0: got %h want %h", a0, e0); end
      n_vec++; if (a1 !== {2'b10, 48'd0}) begin n_err++; $display("FAIL short_dut1: got %h want %h", a1, {2'b10, 48'd0}); end
   endtask

   task automatic test_single_run();
      logic [49:0] a0, a1, b0, b1, e0, e1;
      bit mask[];
      for (int r = 0; r < 8; r++) begin
         mask = new[120];
         for (int c = 0; c < 120; c++) mask[c] = (r == 7 && c >= 100 && c <= 107);
         drive_line(mask);
      end
      model_fb(e0, e1);
      do_fb(a0, a1, b0, b1);
      n_vec++; if (a0 !== e0) begin n_err++; $display("FAIL single_dut0: got %h want %h", a0, e0); end
      n_vec++; if (a1 !== e1) begin n_err++; $display("FAIL single_dut1: got %h want %h", a1, e1); end
      n_vec++; if (a1 !== {2'b11, 12'd100, 12'd107, 12'd7, 12'd7}) begin
         n_err++; $display("FAIL single_const: got %h want box 100..107 x 7..7", a1); end
   endtask

   task automatic test_saturate();
      logic [49:0] a0, a1, b0, b1, e0, e1;
      bit mask[];
      mask = new[4100];
      for (int c = 0; c < 4100; c++) mask[c] = (c >= 4090);
      drive_line(mask);
      model_fb(e0, e1);
      do_fb(a0, a1, b0, b1);
      n_vec++; if (a1 !== e1) begin n_err++; $display("FAIL sat_dut1: got %h want %h", a1, e1); end
      n_vec++; if (a1 !== {2'b11, 12'd4090, 12'd4095, 12'd0, 12'd0}) begin
         n_err++; $display("FAIL sat_const: got %h want x 4090..4095", a1); end
      n_vec++; if (a0 !== e0) begin n_err++; $display("FAIL sat_dut0: got %h want %h", a0, e0); end
   endtask

   task automatic test_collision();
      logic [49:0] a0, a1, b0, b1, e0, e1;
      bit mask[];
      for (int r = 0; r < 3; r++) begin
         mask = new[16];
         for (int c = 0; c < 16; c++) mask[c] = (r == 2 && c <= 9);
         drive_line(mask);
      end
      // Three skin pixels, then vsync rises on what would be the fourth skin pixel
      repeat (3) begin de = 1'b1; mo = 1'b1; tick(); end
      model_fb(e0, e1);
      vs = 1'b1;
      tick();
      a0 = obs0(); a1 = obs1();
      de = 1'b0; mo = 1'b0;
      tick();
      vs = 1'b0;
      tick();
      n_vec++; if (a1 !== e1) begin n_err++; $display("FAIL collide_dut1: got %h want %h", a1, e1); end
      n_vec++; if (a1 !== {2'b11, 12'd0, 12'd9, 12'd2, 12'd2}) begin
         n_err++; $display("FAIL collide_const: got %h want box 0..9 x 2..2", a1); end
      n_vec++; if (a0 !== e0) begin n_err++; $display("FAIL collide_dut0: got %h want %h", a0, e0); end
      model_fb(e0, e1);
      do_fb(a0, a1, b0, b1);
      n_vec++; if (a1 !== e1) begin n_err++; $display("FAIL collide_next_dut1: got %h want %h", a1, e1); end
   endtask

   task automatic test_back_to_back();
      logic [49:0] a0, a1, b0, b1, e0, e1;
      for (int i = 0; i < 3; i++) begin
         model_fb(e0, e1);
         do_fb(a0, a1, b0, b1);
         n_vec++; if (a0 !== e0) begin n_err++; $display("FAIL b2b_dut0[%0d]: got %h want %h", i, a0, e0); end
         n_vec++; if (a1 !== {2'b10, 48'd0}) begin n_err++; $display("FAIL b2b_dut1[%0d]: got %h want %h", i, a1, {2'b10, 48'd0}); end
         n_vec++; if (b1 !== held1) begin n_err++; $display("FAIL b2b_hold[%0d]: got %h want %h", i, b1, held1); end
      end
   endtask

   task automatic test_reset_mid();
      logic [49:0] a0, a1, b0, b1, e0, e1, o0;
      bit mask[];
      for (int r = 0; r < 3; r++) begin
         mask = new[24];
         for (int c = 0; c < 24; c++) mask[c] = (c < 20);
         drive_line(mask);
      end
      de = 1'b1; mo = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      o0 = obs0();
      n_vec++; if (o0 !== 50'd0) begin n_err++; $display("FAIL midrst_clear: got %h want %h", o0, 50'd0); end
      de = 1'b0; mo = 1'b0;
      rst = 1'b0;
      model_reset();
      tick();
      model_fb(e0, e1);
      do_fb(a0, a1, b0, b1);
      n_vec++; if (a1 !== e1) begin n_err++; $display("FAIL midrst_first_fb: got %h want %h", a1, e1); end
      for (int r = 0; r < 2; r++) begin
         mask = new[24];
         for (int c = 0; c < 24; c++) mask[c] = (c >= 6 && c < 18);
         drive_line(mask);
      end
      model_fb(e0, e1);
      do_fb(a0, a1, b0, b1);
      n_vec++; if (a1 !== e1) begin n_err++; $display("FAIL midrst_second_fb: got %h want %h", a1, e1); end
      n_vec++; if (a0 !== e0) begin n_err++; $display("FAIL midrst_second_dut0: got %h want %h", a0, e0); end
   endtask

   task automatic test_random();
      logic [49:0] a0, a1, b0, b1, e0, e1;
      bit mask[];
      for (int f = 0; f < 8; f++) begin
         int nl;
         int len;
         nl  = $urandom_range(10, 3);
         len = $urandom_range(48, 8);
         for (int r = 0; r < nl; r++) begin
            bit prev;
            prev = 1'b0;
            mask = new[len];
            for (int c = 0; c < len; c++) begin
               mask[c] = ($urandom_range(99) < (prev ? 85 : 25));
               prev = mask[c];
            end
            drive_line(mask);
         end
         model_fb(e0, e1);
         do_fb(a0, a1, b0, b1);
         n_vec++; if (a0 !== e0) begin n_err++; $display("FAIL rand_dut0[%0d]: got %h want %h", f, a0, e0); end
         n_vec++; if (a1 !== e1) begin n_err++; $display("FAIL rand_dut1[%0d]: got %h want %h", f, a1, e1); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_square();
      test_short_runs();
      test_single_run();
      test_saturate();
      test_collision();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
